// File: rtl/ifu_idu_fetch_queue.sv
// Decoupling queue between the I-cache fetch stage and decode. It holds up to DEPTH packets
// and stops accepting new packets after a faulting fetch until the next flush.
module ifu_idu_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [31:0]   i_pc,
    input  logic [31:0]   i_inst,
    input  logic          i_exception,
    input  logic [3:0]    i_mcause,
    input  logic          i_predict,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [31:0]   o_pc,
    output logic [31:0]   o_inst,
    output logic          o_exception,
    output logic [3:0]    o_mcause,
    output logic          o_predict,
    input  logic          i_flush,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {StRun, StBlocked} state_e;

    state_e        r_state;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [69:0]   r_mem [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    // Depends only on registered state (and reset), never on i_ready.
    assign o_ready = i_reset & (r_state == StRun) & ~w_full;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    assign {o_pc, o_inst, o_exception, o_mcause, o_predict} = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= StRun;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_state  <= StRun;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
            // Anything fetched after a fault is wrong-path; stop accepting until flushed.
            if (w_push && i_exception) begin
                r_state <= StBlocked;
            end
        end
    end

    // Entry storage carries no reset; only written on an accepted, non-flushed push.
    always_ff @(posedge i_clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= {i_pc, i_inst, i_exception, i_mcause, i_predict};
        end
    end

endmodule

// File: tb/tb_ifu_idu_fetch_queue.sv
// Self-checking bench for ifu_idu_fetch_queue: a vector table for fill/drain plus hand-written
// sequences, with a scoreboard queue modelling occupancy, order, blocking and flush.
module tb_ifu_idu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc;
    logic [31:0] i_inst;
    logic        i_exception;
    logic [3:0]  i_mcause;
    logic        i_predict;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_exception;
    logic [3:0]  o_mcause;
    logic        o_predict;
    logic        i_flush;
    logic [2:0]  o_count;

    always #5 clk = ~clk;

    ifu_idu_fetch_queue #(.DEPTH(4), .AW(2)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_pc        (i_pc),
        .i_inst      (i_inst),
        .i_exception (i_exception),
        .i_mcause    (i_mcause),
        .i_predict   (i_predict),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_pc        (o_pc),
        .o_inst      (o_inst),
        .o_exception (o_exception),
        .o_mcause    (o_mcause),
        .o_predict   (o_predict),
        .i_flush     (i_flush),
        .o_count     (o_count)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [3:0]  mc;
        logic        pred;
        logic        rdy;
        logic        fl;
        logic [2:0]  ecnt;
        logic        erdy;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [69:0] m_q[$];
    bit          m_blk = 1'b0;
    vec_t        tbl[11];

    function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic rdy,
                                 input logic [2:0] ecnt, input logic erdy);
        vec_t r;
        r.v    = v;
        r.pc   = pc;
        r.inst = pc + 32'h100;
        r.exc  = 1'b0;
        r.mc   = pc[5:2];
        r.pred = pc[2];
        r.rdy  = rdy;
        r.fl   = 1'b0;
        r.ecnt = ecnt;
        r.erdy = erdy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        i_valid     = v.v;
        i_pc        = v.pc;
        i_inst      = v.inst;
        i_exception = v.exc;
        i_mcause    = v.mc;
        i_predict   = v.pred;
        i_ready     = v.rdy;
        i_flush     = v.fl;
    endtask

    task automatic pkt(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic exc, input logic [3:0] mc, input logic rdy, input logic fl);
        vec_t t;
        t      = mkv(v, pc, rdy, 3'd0, 1'b0);
        t.inst = inst;
        t.exc  = exc;
        t.mc   = mc;
        t.fl   = fl;
        drive(t);
    endtask

    // Check outputs against the model at the falling edge, then advance the model at the edge.
    task automatic step();
        bit m_rdy;
        bit push;
        bit pop;
        @(negedge clk);
        m_rdy = rst_n && !m_blk && (m_q.size() < 4);
        chk("ready", 70'(o_ready), 70'(m_rdy));
        chk("valid", 70'(o_valid), 70'(m_q.size() != 0));
        chk("count", 70'(o_count), 70'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("head", {o_pc, o_inst, o_exception, o_mcause, o_predict}, m_q[0]);
        end
        push = (i_valid === 1'b1) && m_rdy;
        pop  = (m_q.size() != 0) && (i_ready === 1'b1);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_blk = 1'b0;
        end else if (i_flush) begin
            m_q.delete();
            m_blk = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({i_pc, i_inst, i_exception, i_mcause, i_predict});
                if (i_exception) m_blk = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        tbl[0]  = mkv(1'b1, 32'h8000_0000, 1'b0, 3'd1, 1'b1);
        tbl[1]  = mkv(1'b1, 32'h8000_0004, 1'b0, 3'd2, 1'b1);
        tbl[2]  = mkv(1'b1, 32'h8000_0008, 1'b0, 3'd3, 1'b1);
        tbl[3]  = mkv(1'b1, 32'h8000_000C, 1'b0, 3'd4, 1'b0);
        tbl[4]  = mkv(1'b1, 32'h8000_0010, 1'b1, 3'd3, 1'b1);  // full: pop only, no push
        tbl[5]  = mkv(1'b1, 32'h8000_0010, 1'b0, 3'd4, 1'b0);
        tbl[6]  = mkv(1'b0, 32'h0,         1'b1, 3'd3, 1'b1);
        tbl[7]  = mkv(1'b0, 32'h0,         1'b1, 3'd2, 1'b1);
        tbl[8]  = mkv(1'b0, 32'h0,         1'b1, 3'd1, 1'b1);
        tbl[9]  = mkv(1'b0, 32'h0,         1'b1, 3'd0, 1'b1);
        tbl[10] = mkv(1'b0, 32'h0,         1'b1, 3'd0, 1'b1);

        rst_n = 1'b1;
        pkt(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;

        // Reset held for three cycles, then released between edges.
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();
        chk("rst_count", 70'(o_count), 70'd0);

        // Fill/drain table, including a pop attempted together with a push on a full queue.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i]);
            step();
            chk("tbl_count", 70'(o_count), 70'(tbl[i].ecnt));
            chk("tbl_ready", 70'(o_ready), 70'(tbl[i].erdy));
        end

        // Steady push+pop at count 2 across several pointer wraps.
        for (int i = 0; i < 2; i++) begin
            pkt(1'b1, 32'h9000_0000 + 32'(i * 4), $urandom, 1'b0, 4'h0, 1'b0, 1'b0);
            step();
        end
        for (int i = 2; i < 12; i++) begin
            pkt(1'b1, 32'h9000_0000 + 32'(i * 4), $urandom, 1'b0, 4'(i), 1'b1, 1'b0);
            step();
            chk("wrap_count", 70'(o_count), 70'd2);
        end
        pkt(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        step();
        step();
        chk("wrap_drain", 70'(o_count), 70'd0);

        // Faulting fetch blocks further pushes; both queued packets still drain.
        pkt(1'b1, 32'hA000_0000, 32'h0000_0013, 1'b0, 4'h0, 1'b0, 1'b0);
        step();
        pkt(1'b1, 32'hA000_0004, 32'h1234_5678, 1'b1, 4'h1, 1'b0, 1'b0);
        step();
        chk("blk_ready", 70'(o_ready), 70'd0);
        pkt(1'b1, 32'hA000_0008, 32'h0000_0013, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("blk_hold", 70'(o_count), 70'd2);
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("blk_empty", 70'(o_valid), 70'd0);
        chk("blk_still", 70'(o_ready), 70'd0);
        pkt(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
        chk("blk_flush", 70'(o_ready), 70'd1);

        // Flush with a concurrent push at count 3: the pushed packet is dropped.
        for (int i = 0; i < 3; i++) begin
            pkt(1'b1, 32'hB000_0000 + 32'(i * 4), $urandom, 1'b0, 4'h2, 1'b0, 1'b0);
            step();
        end
        pkt(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 4'h3, 1'b0, 1'b1);
        step();
        chk("fl_count", 70'(o_count), 70'd0);
        chk("fl_valid", 70'(o_valid), 70'd0);
        pkt(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        step();
        step();
        chk("fl_gone", 70'(o_valid), 70'd0);

        // Asynchronous reset between edges with count 3.
        for (int i = 0; i < 3; i++) begin
            pkt(1'b1, 32'hC000_0000 + 32'(i * 4), $urandom, 1'b0, 4'h5, 1'b0, 1'b0);
            step();
        end
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 70'(o_valid), 70'd0);
        chk("arst_count", 70'(o_count), 70'd0);
        chk("arst_ready", 70'(o_ready), 70'd0);
        m_q.delete();
        m_blk = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Unknown i_ready on an empty queue must leave the state alone.
        i_ready = 1'bx;
        step();
        chk("x_ready", 70'(o_count), 70'd0);
        i_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
